// File: rtl/uart_pkg.sv
// uart_pkg: shared types and sizing helpers for the oversampling UART receiver.
// Holds the parity selector, receiver FSM states and counter-width helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  // Baud counter width for a given bit period.
  function automatic int cnt_w(input int clks);
    return $clog2(clks);
  endfunction

  // Bit counter width for a given data width.
  function automatic int bit_w(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: held-word handshake from the receiver to the cipher input.
// master: data, data_valid, parity_err, frame_err, overrun out; data_ready in.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, data_valid,
    output parity_err, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid,
    input  parity_err, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser, previous-value flop, falling-edge pulse.
// Ports: clk, rst, rx_i (async line), rx_s_o (synced line), fall_o (1->0 edge).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // All flops reset to the idle-high line level so reset never fakes a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rx_s_o = s2_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: mid-bit-sampling UART receiver with parity/framing/overrun flags.
// Ports: clk, rst (async, high), rx (line), bus (held-word handshake), busy.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 16,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_os_if.master bus,
  output logic         busy
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = bit_w(DATA_BITS);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
  localparam bit            PAR_EN = (PARITY != PAR_NONE);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A high sample mid-start means the edge was a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          if (bit_q == LAST_D) begin
            bit_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          perr_d  = (PARITY == PAR_ODD) ? ~(^sh_q ^ rx_s)
                                        :  (^sh_q ^ rx_s);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (bit_q == LAST_S) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  assign accept = vld_q & bus.data_ready;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    ovr_d  = ovr_q;
    if (commit) begin
      data_d = sh_q;
      vld_d  = 1'b1;
      pe_d   = perr_q;
      fe_d   = ferr_d;
      // Lost word only if the held one was still pending this edge.
      ovr_d  = vld_q & ~accept;
    end else if (accept) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      pe_q   <= pe_d;
      fe_q   <= fe_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = vld_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for 8N1, 8E1 and 8N2 receivers at 16 clk/bit.
// Ports: none.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_n1 = 1'b1;
  logic rx_e1 = 1'b1;
  logic rx_n2 = 1'b1;
  logic busy_n1, busy_e1, busy_n2;

  always #5 clk = ~clk;

  uart_rx_os_if #(.DATA_BITS(8)) if_n1 ();
  uart_rx_os_if #(.DATA_BITS(8)) if_e1 ();
  uart_rx_os_if #(.DATA_BITS(8)) if_n2 ();

  uart_rx_os #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(1)
  ) u_n1 (
    .clk(clk), .rst(rst), .rx(rx_n1),
    .bus(if_n1), .busy(busy_n1)
  );

  uart_rx_os #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(PAR_EVEN), .STOP_BITS(1)
  ) u_e1 (
    .clk(clk), .rst(rst), .rx(rx_e1),
    .bus(if_e1), .busy(busy_e1)
  );

  uart_rx_os #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(2)
  ) u_n2 (
    .clk(clk), .rst(rst), .rx(rx_n2),
    .bus(if_n2), .busy(busy_n2)
  );

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       vld [3];
  logic [7:0] dat [3];
  logic       pe  [3];
  logic       fe  [3];
  logic       ov  [3];

  assign vld[0] = if_n1.data_valid;
  assign vld[1] = if_e1.data_valid;
  assign vld[2] = if_n2.data_valid;
  assign dat[0] = if_n1.data;
  assign dat[1] = if_e1.data;
  assign dat[2] = if_n2.data;
  assign pe[0]  = if_n1.parity_err;
  assign pe[1]  = if_e1.parity_err;
  assign pe[2]  = if_n2.parity_err;
  assign fe[0]  = if_n1.frame_err;
  assign fe[1]  = if_e1.frame_err;
  assign fe[2]  = if_n2.frame_err;
  assign ov[0]  = if_n1.overrun;
  assign ov[1]  = if_e1.overrun;
  assign ov[2]  = if_n2.overrun;

  int         rise_n [3] = '{0, 0, 0};
  int         rise_c [3] = '{0, 0, 0};
  logic [7:0] cap_d  [3];
  logic       cap_pe [3];
  logic       cap_fe [3];
  logic       cap_ov [3];
  logic       pv     [3] = '{1'b0, 1'b0, 1'b0};

  int   busy_rise_n = 0;
  int   busy_rise_c = 0;
  int   busy_fall_c = 0;
  logic pbusy = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && !pv[k]) begin
        rise_n[k] = rise_n[k] + 1;
        rise_c[k] = cyc;
        cap_d[k]  = dat[k];
        cap_pe[k] = pe[k];
        cap_fe[k] = fe[k];
        cap_ov[k] = ov[k];
      end
      pv[k] = vld[k];
    end
    if (busy_n1 && !pbusy) begin
      busy_rise_n = busy_rise_n + 1;
      busy_rise_c = cyc;
    end
    if (!busy_n1 && pbusy) busy_fall_c = cyc;
    pbusy = busy_n1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0: rx_n1 = v;
      1: rx_e1 = v;
      default: rx_n2 = v;
    endcase
  endtask

  // Sends n line bits LSB first, one bit period each; starts at posedge+1.
  task automatic send_raw(input int sel, input logic [15:0] bits,
                          input int n);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      cycles(CPB);
    end
  endtask

  initial begin
    if_n1.data_ready = 1'b1;
    if_e1.data_ready = 1'b1;
    if_n2.data_ready = 1'b1;
    cycles(3);
    chk("rst_data", {24'd0, if_n1.data}, 32'h0);
    chk("rst_valid", {31'd0, if_n1.data_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy_n1}, 32'h0);
    rst = 1'b0;
    cycles(4);
    chk("idle_pe", {31'd0, if_n1.parity_err}, 32'h0);
    chk("idle_fe", {31'd0, if_n1.frame_err}, 32'h0);
    chk("idle_ov", {31'd0, if_n1.overrun}, 32'h0);

    // 8N1 0xA5 with exact timing
    send_raw(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    cycles(4);
    chk("n1_data", {24'd0, cap_d[0]}, 32'hA5);
    chk("n1_pe", {31'd0, cap_pe[0]}, 32'h0);
    chk("n1_fe", {31'd0, cap_fe[0]}, 32'h0);
    chk("n1_ov", {31'd0, cap_ov[0]}, 32'h0);
    chk("n1_valid_t", rise_c[0] - start_cyc, 32'd155);
    chk("n1_busy_rise_t", busy_rise_c - start_cyc, 32'd3);
    chk("n1_busy_fall_t", busy_fall_c - start_cyc, 32'd155);
    chk("n1_valid_pulse", {31'd0, if_n1.data_valid}, 32'h0);
    chk("n1_rises", rise_n[0], 32'd1);

    // 8E1 0x3C: parity bit 1 is wrong, then 0 is right
    send_raw(1, {5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    cycles(4);
    chk("e1_data_a", {24'd0, cap_d[1]}, 32'h3C);
    chk("e1_pe_a", {31'd0, cap_pe[1]}, 32'h1);
    send_raw(1, {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    cycles(4);
    chk("e1_data_b", {24'd0, cap_d[1]}, 32'h3C);
    chk("e1_pe_b", {31'd0, cap_pe[1]}, 32'h0);
    chk("e1_fe_b", {31'd0, cap_fe[1]}, 32'h0);
    chk("e1_rises", rise_n[1], 32'd2);

    // 8N2: second stop low, then line held low 40 bit times
    send_raw(2, {5'd0, 1'b0, 1'b1, 8'h96, 1'b0}, 11);
    cycles(40 * CPB);
    drive(2, 1'b1);
    cycles(2 * CPB);
    chk("n2_data", {24'd0, cap_d[2]}, 32'h96);
    chk("n2_fe", {31'd0, cap_fe[2]}, 32'h1);
    chk("n2_rises", rise_n[2], 32'd1);
    chk("n2_busy_end", {31'd0, busy_n2}, 32'h0);

    // Start glitch: 3 cycles low
    drive(0, 1'b0);
    cycles(3);
    drive(0, 1'b1);
    cycles(3 * CPB);
    chk("gl_busy_n", busy_rise_n, 32'd2);
    chk("gl_busy_len", busy_fall_c - busy_rise_c, 32'd8);
    chk("gl_rises", rise_n[0], 32'd1);
    chk("gl_busy_end", {31'd0, busy_n1}, 32'h0);

    // Overrun: two back-to-back words with nobody accepting
    if_n1.data_ready = 1'b0;
    send_raw(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
    send_raw(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
    cycles(2);
    chk("ov_data", {24'd0, if_n1.data}, 32'h22);
    chk("ov_flag", {31'd0, if_n1.overrun}, 32'h1);
    chk("ov_valid", {31'd0, if_n1.data_valid}, 32'h1);
    chk("ov_fe", {31'd0, if_n1.frame_err}, 32'h0);
    chk("ov_rises", rise_n[0], 32'd2);
    if_n1.data_ready = 1'b1;
    cycles(1);
    chk("ov_acc_valid", {31'd0, if_n1.data_valid}, 32'h0);
    chk("ov_acc_flag", {31'd0, if_n1.overrun}, 32'h0);

    // Reset during data bit 4, then a clean frame
    send_raw(0, {11'd0, 4'b0000, 1'b0}, 5);
    drive(0, 1'b1);
    cycles(8);
    chk("mr_busy_pre", {31'd0, busy_n1}, 32'h1);
    rst = 1'b1;
    #2;
    chk("mr_data", {24'd0, if_n1.data}, 32'h0);
    chk("mr_valid", {31'd0, if_n1.data_valid}, 32'h0);
    chk("mr_busy", {31'd0, busy_n1}, 32'h0);
    cycles(3);
    rst = 1'b0;
    cycles(5);
    send_raw(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    cycles(4);
    chk("mr_rises", rise_n[0], 32'd3);
    chk("mr_new_data", {24'd0, cap_d[0]}, 32'h5A);
    chk("mr_new_pe", {31'd0, cap_pe[0]}, 32'h0);
    chk("mr_new_fe", {31'd0, cap_fe[0]}, 32'h0);
    chk("mr_new_ov", {31'd0, cap_ov[0]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
